// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback/commit stage
package wb_pkg;
  typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_MEM = 2'd1, SRC_LINK = 2'd2} reg_src_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} mem_size_t;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, HALTED} wb_state_t;
  localparam int LINK_OFS = 4;
endpackage

// File: rtl/wb_commit_unit_if.sv
// wb_commit_unit_if: MEM-stage handshake and load-data bus into the commit stage
interface wb_commit_unit_if #(parameter int XLEN = 32, parameter int REG_AW = 5);
  logic in_valid;
  logic in_ready;
  logic [1:0] register_src;
  logic reg_write;
  logic [REG_AW-1:0] rd_num_in;
  logic [1:0] mem_size;
  logic is_unsigned;
  logic [$clog2(XLEN/8)-1:0] byte_number;
  logic [XLEN-1:0] ALU_result;
  logic [XLEN-1:0] inst_addr;
  logic halted_controller;
  logic mem_valid;
  logic [XLEN-1:0] cache_data_out;
  modport master(output in_valid, register_src, reg_write, rd_num_in, mem_size, is_unsigned,
                 byte_number, ALU_result, inst_addr, halted_controller, mem_valid, cache_data_out,
                 input in_ready);
  modport slave(input in_valid, register_src, reg_write, rd_num_in, mem_size, is_unsigned,
                byte_number, ALU_result, inst_addr, halted_controller, mem_valid, cache_data_out,
                output in_ready);
endinterface

// File: rtl/wb_load_align.sv
// wb_load_align: big-endian lane select and sign/zero extension of load data (WB_HALFWORD_EN adds halfwords)
module wb_load_align import wb_pkg::*; #(parameter int XLEN = 32) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0] mem_size,
  input  logic is_unsigned,
  input  logic [$clog2(XLEN/8)-1:0] byte_number,
  output logic [XLEN-1:0] ld
);
  localparam int L = XLEN/8;
  localparam int OW = $clog2(L);
  logic [OW-1:0] lb;
  logic [7:0] b8;
  logic [XLEN-1:0] bx, wx;
  // offset 0 is the most significant lane
  assign lb = OW'(L-1) - byte_number;
  assign b8 = data[8*lb +: 8];
  assign bx = {{(XLEN-8){b8[7] & !is_unsigned}}, b8};
  if (XLEN == 32) begin : g_w32
    assign wx = data;
  end else begin : g_wx
    logic [OW-1:0] lw;
    logic [31:0] w32;
    assign lw = OW'(L-4) - {byte_number[OW-1:2], 2'b00};
    assign w32 = data[8*lw +: 32];
    assign wx = {{(XLEN-32){w32[31] & !is_unsigned}}, w32};
  end
`ifdef WB_HALFWORD_EN
  logic [OW-1:0] lh;
  logic [15:0] h16;
  logic [XLEN-1:0] hx;
  assign lh = OW'(L-2) - {byte_number[OW-1:1], 1'b0};
  assign h16 = data[8*lh +: 16];
  assign hx = {{(XLEN-16){h16[15] & !is_unsigned}}, h16};
  assign ld = mem_size == SZ_BYTE ? bx : mem_size == SZ_HALF ? hx : wx;
`else
  assign ld = mem_size == SZ_BYTE ? bx : wx;
`endif
endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: writeback/commit stage with load-data wait, sticky halt and retire counter
// Define WB_HALFWORD_EN to enable halfword loads.
module wb_commit_unit import wb_pkg::*; #(parameter int XLEN = 32, parameter int REG_AW = 5) (
  input  logic clk,
  input  logic rst,
  wb_commit_unit_if.slave mem,
  output logic rd_we,
  output logic [REG_AW-1:0] rd_num,
  output logic [XLEN-1:0] rd_data,
  output logic halted,
  output logic [XLEN-1:0] retired_count
);
  localparam int BW = $clog2(XLEN/8);
  typedef struct packed {
    logic [1:0] src;
    logic reg_write;
    logic [REG_AW-1:0] rd;
    logic [1:0] size;
    logic is_unsigned;
    logic [BW-1:0] bn;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] pc;
    logic halt;
  } instr_t;
  wb_state_t state, state_n;
  instr_t live, cap, cur;
  logic accept, commit;
  logic [XLEN-1:0] ld, result;
  assign live = '{src: mem.register_src, reg_write: mem.reg_write, rd: mem.rd_num_in,
                  size: mem.mem_size, is_unsigned: mem.is_unsigned, bn: mem.byte_number,
                  alu: mem.ALU_result, pc: mem.inst_addr, halt: mem.halted_controller};
  // in IDLE the instruction commits straight from the bus; while waiting it comes from the capture
  assign cur = state == IDLE ? live : cap;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb state_n = commit ? (cur.halt ? HALTED : IDLE) : accept ? WAIT_MEM : state;
  always_comb begin
    mem.in_ready = state == IDLE && !rst;
    accept = mem.in_valid && mem.in_ready;
    commit = (accept && (cur.src != SRC_MEM || mem.mem_valid)) || (state == WAIT_MEM && mem.mem_valid);
  end
  wb_load_align #(.XLEN(XLEN)) u_align (
    .data(mem.cache_data_out), .mem_size(cur.size), .is_unsigned(cur.is_unsigned),
    .byte_number(cur.bn), .ld(ld)
  );
  assign result = cur.src == SRC_MEM ? ld : cur.src == SRC_LINK ? cur.pc + XLEN'(LINK_OFS) : cur.alu;
  always_ff @(posedge clk)
    if (accept) cap <= live;
  always_ff @(posedge clk)
    if (rst) begin
      rd_we <= 1'b0;
      rd_num <= '0;
      rd_data <= '0;
      halted <= 1'b0;
      retired_count <= '0;
    end else begin
      rd_we <= commit && cur.reg_write && cur.rd != '0;
      if (commit) begin
        rd_num <= cur.rd;
        rd_data <= result;
        retired_count <= retired_count + 1'b1;
        if (cur.halt) halted <= 1'b1;
      end
    end
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: directed vectors with hand-computed expectations for wb_commit_unit
module tb_wb_commit_unit;
  logic clk = 0;
  logic rst;
  logic rd_we, halted;
  logic [4:0] rd_num;
  logic [31:0] rd_data, retired_count;
  int nvec = 0, nerr = 0;
  logic [31:0] exp_cnt = 0;
  wb_commit_unit_if #(.XLEN(32), .REG_AW(5)) bus();
  wb_commit_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .mem(bus.slave), .rd_we(rd_we), .rd_num(rd_num),
    .rd_data(rd_data), .halted(halted), .retired_count(retired_count)
  );
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] src, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sz, input logic uns, input logic [1:0] bn,
                       input logic [31:0] alu, input logic [31:0] pc, input logic hlt,
                       input logic mv, input logic [31:0] cd);
    bus.in_valid = 1; bus.register_src = src; bus.reg_write = rw; bus.rd_num_in = rd;
    bus.mem_size = sz; bus.is_unsigned = uns; bus.byte_number = bn; bus.ALU_result = alu;
    bus.inst_addr = pc; bus.halted_controller = hlt; bus.mem_valid = mv; bus.cache_data_out = cd;
  endtask

  task automatic test_reset();
    rst = 1;
    step(); step();
    nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
    nvec++; if (rd_we !== 1'b0) begin nerr++; $display("FAIL reset_rd_we got %b exp 0", rd_we); end
    nvec++; if (rd_num !== 5'd0) begin nerr++; $display("FAIL reset_rd_num got %0d exp 0", rd_num); end
    nvec++; if (rd_data !== 32'h0) begin nerr++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    nvec++; if (halted !== 1'b0) begin nerr++; $display("FAIL reset_halted got %b exp 0", halted); end
    nvec++; if (retired_count !== 32'h0) begin nerr++; $display("FAIL reset_count got %0d exp 0", retired_count); end
    rst = 0;
    #1;
    nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_in_ready got %b exp 1", bus.in_ready); end
    exp_cnt = 0;
  endtask

  task automatic test_alu();
    drive(2'b00, 1, 5'd8, 2'b10, 0, 2'd0, 32'h12345678, 32'h0, 0, 0, 32'h0);
    step();
    bus.in_valid = 0;
    exp_cnt++;
    nvec++; if (rd_we !== 1'b1) begin nerr++; $display("FAIL alu_rd_we got %b exp 1", rd_we); end
    nvec++; if (rd_num !== 5'd8) begin nerr++; $display("FAIL alu_rd_num got %0d exp 8", rd_num); end
    nvec++; if (rd_data !== 32'h12345678) begin nerr++; $display("FAIL alu_rd_data got %h exp 12345678", rd_data); end
    nvec++; if (retired_count !== exp_cnt) begin nerr++; $display("FAIL alu_count got %0d exp %0d", retired_count, exp_cnt); end
    step();
    nvec++; if (rd_we !== 1'b0) begin nerr++; $display("FAIL alu_strobe_len got %b exp 0", rd_we); end
    nvec++; if (rd_data !== 32'h12345678) begin nerr++; $display("FAIL alu_hold got %h exp 12345678", rd_data); end
  endtask

  task automatic test_byte();
    logic [31:0] exp_d [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00000011};
    logic uns [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0] off [3] = '{2'd0, 2'd0, 2'd3};
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 1, 5'd9, 2'b00, uns[i], off[i], 32'h0, 32'h0, 0, 1, 32'h80FF0011);
      step();
      bus.in_valid = 0; bus.mem_valid = 0;
      exp_cnt++;
      nvec++; if (rd_data !== exp_d[i]) begin nerr++; $display("FAIL byte%0d_data got %h exp %h", i, rd_data, exp_d[i]); end
      nvec++; if (rd_we !== 1'b1) begin nerr++; $display("FAIL byte%0d_rd_we got %b exp 1", i, rd_we); end
    end
    nvec++; if (retired_count !== exp_cnt) begin nerr++; $display("FAIL byte_count got %0d exp %0d", retired_count, exp_cnt); end
  endtask

  task automatic test_wait_mem();
    drive(2'b01, 1, 5'd10, 2'b10, 0, 2'd0, 32'h0, 32'h0, 0, 0, 32'h55555555);
    step();
    bus.in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL wait%0d_in_ready got %b exp 0", i, bus.in_ready); end
      nvec++; if (rd_we !== 1'b0) begin nerr++; $display("FAIL wait%0d_rd_we got %b exp 0", i, rd_we); end
      if (i < 2) step();
    end
    bus.mem_valid = 1; bus.cache_data_out = 32'hDEADBEEF;
    step();
    bus.mem_valid = 0;
    exp_cnt++;
    nvec++; if (rd_we !== 1'b1) begin nerr++; $display("FAIL wait_commit_rd_we got %b exp 1", rd_we); end
    nvec++; if (rd_num !== 5'd10) begin nerr++; $display("FAIL wait_rd_num got %0d exp 10", rd_num); end
    nvec++; if (rd_data !== 32'hDEADBEEF) begin nerr++; $display("FAIL wait_rd_data got %h exp deadbeef", rd_data); end
    nvec++; if (retired_count !== exp_cnt) begin nerr++; $display("FAIL wait_count got %0d exp %0d", retired_count, exp_cnt); end
    nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL wait_ready_back got %b exp 1", bus.in_ready); end
    bus.mem_valid = 1;
    step();
    bus.mem_valid = 0;
    nvec++; if (rd_we !== 1'b0) begin nerr++; $display("FAIL idle_mem_valid_rd_we got %b exp 0", rd_we); end
    nvec++; if (retired_count !== exp_cnt) begin nerr++; $display("FAIL idle_mem_valid_count got %0d exp %0d", retired_count, exp_cnt); end
  endtask

  task automatic test_link();
    drive(2'b10, 1, 5'd0, 2'b10, 0, 2'd0, 32'h0, 32'hFFFFFFFC, 0, 0, 32'h0);
    step();
    exp_cnt++;
    nvec++; if (rd_we !== 1'b0) begin nerr++; $display("FAIL link_r0_rd_we got %b exp 0", rd_we); end
    nvec++; if (rd_data !== 32'h0) begin nerr++; $display("FAIL link_wrap_data got %h exp 0", rd_data); end
    nvec++; if (retired_count !== exp_cnt) begin nerr++; $display("FAIL link_r0_count got %0d exp %0d", retired_count, exp_cnt); end
    drive(2'b10, 1, 5'd31, 2'b10, 0, 2'd0, 32'h0, 32'h00000100, 0, 0, 32'h0);
    step();
    bus.in_valid = 0;
    exp_cnt++;
    nvec++; if (rd_we !== 1'b1 || rd_num !== 5'd31) begin nerr++; $display("FAIL link_r31 got we=%b rd=%0d exp we=1 rd=31", rd_we, rd_num); end
    nvec++; if (rd_data !== 32'h00000104) begin nerr++; $display("FAIL link_data got %h exp 104", rd_data); end
  endtask

  task automatic test_half();
    logic [31:0] e0, e1;
`ifdef WB_HALFWORD_EN
    e0 = 32'hFFFFABCD; e1 = 32'h00001234;
`else
    e0 = 32'h1234ABCD; e1 = 32'h1234ABCD;
`endif
    drive(2'b01, 1, 5'd12, 2'b01, 0, 2'd2, 32'h0, 32'h0, 0, 1, 32'h1234ABCD);
    step();
    exp_cnt++;
    nvec++; if (rd_data !== e0) begin nerr++; $display("FAIL half_off2_signed got %h exp %h", rd_data, e0); end
    drive(2'b01, 1, 5'd12, 2'b01, 1, 2'd0, 32'h0, 32'h0, 0, 1, 32'h1234ABCD);
    step();
    bus.in_valid = 0; bus.mem_valid = 0;
    exp_cnt++;
    nvec++; if (rd_data !== e1) begin nerr++; $display("FAIL half_off0_unsigned got %h exp %h", rd_data, e1); end
    nvec++; if (retired_count !== exp_cnt) begin nerr++; $display("FAIL half_count got %0d exp %0d", retired_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] src [3] = '{2'b00, 2'b11, 2'b00};
    logic [31:0] val [3] = '{32'h0000000A, 32'h0000000B, 32'hC0DE0000};
    for (int i = 0; i < 3; i++) begin
      drive(src[i], 1, 5'(i + 1), 2'b10, 0, 2'd0, val[i], 32'h40, 0, 0, 32'h0);
      step();
      exp_cnt++;
      nvec++; if (rd_we !== 1'b1 || rd_num !== 5'(i + 1)) begin nerr++; $display("FAIL b2b%0d got we=%b rd=%0d exp we=1 rd=%0d", i, rd_we, rd_num, i + 1); end
      nvec++; if (rd_data !== val[i]) begin nerr++; $display("FAIL b2b%0d_data got %h exp %h", i, rd_data, val[i]); end
      nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL b2b%0d_in_ready got %b exp 1", i, bus.in_ready); end
    end
    bus.in_valid = 0;
    nvec++; if (retired_count !== exp_cnt) begin nerr++; $display("FAIL b2b_count got %0d exp %0d", retired_count, exp_cnt); end
  endtask

  task automatic test_halt();
    drive(2'b00, 1, 5'd5, 2'b10, 0, 2'd0, 32'h00000055, 32'h0, 1, 0, 32'h0);
    step();
    exp_cnt++;
    nvec++; if (rd_we !== 1'b1 || rd_data !== 32'h55) begin nerr++; $display("FAIL halt_commit got we=%b data=%h exp we=1 data=55", rd_we, rd_data); end
    nvec++; if (halted !== 1'b1) begin nerr++; $display("FAIL halt_flag got %b exp 1", halted); end
    drive(2'b00, 1, 5'd6, 2'b10, 0, 2'd0, 32'h66, 32'h0, 0, 1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL halted%0d_in_ready got %b exp 0", i, bus.in_ready); end
      step();
      nvec++; if (rd_we !== 1'b0 || retired_count !== exp_cnt) begin nerr++; $display("FAIL halted%0d got we=%b cnt=%0d exp we=0 cnt=%0d", i, rd_we, retired_count, exp_cnt); end
    end
    bus.in_valid = 0; bus.mem_valid = 0;
    rst = 1;
    step();
    nvec++; if (halted !== 1'b0 || rd_we !== 1'b0 || rd_num !== 5'd0 || rd_data !== 32'h0 || retired_count !== 32'h0) begin
      nerr++; $display("FAIL halt_reset got h=%b we=%b rd=%0d d=%h c=%0d exp all 0", halted, rd_we, rd_num, rd_data, retired_count);
    end
    rst = 0;
    #1;
    exp_cnt = 0;
    nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL halt_reset_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_reset_in_wait();
    drive(2'b00, 1, 5'd7, 2'b10, 0, 2'd0, 32'h77, 32'h0, 0, 0, 32'h0);
    step();
    exp_cnt++;
    drive(2'b01, 1, 5'd4, 2'b10, 0, 2'd0, 32'h0, 32'h0, 0, 0, 32'h0);
    step();
    bus.in_valid = 0;
    step();
    nvec++; if (retired_count !== exp_cnt || bus.in_ready !== 1'b0) begin nerr++; $display("FAIL pre_drop got cnt=%0d rdy=%b exp cnt=%0d rdy=0", retired_count, bus.in_ready, exp_cnt); end
    rst = 1; bus.mem_valid = 1; bus.cache_data_out = 32'hBAD0BAD0;
    step();
    rst = 0;
    step();
    bus.mem_valid = 0;
    nvec++; if (rd_we !== 1'b0 || rd_data !== 32'h0 || retired_count !== 32'h0) begin
      nerr++; $display("FAIL drop_pending got we=%b d=%h c=%0d exp 0 0 0", rd_we, rd_data, retired_count);
    end
    nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL drop_in_ready got %b exp 1", bus.in_ready); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.register_src = 0; bus.reg_write = 0; bus.rd_num_in = 0;
    bus.mem_size = 0; bus.is_unsigned = 0; bus.byte_number = 0; bus.ALU_result = 0;
    bus.inst_addr = 0; bus.halted_controller = 0; bus.mem_valid = 0; bus.cache_data_out = 0;
    test_reset();
    test_alu();
    test_byte();
    test_wait_mem();
    test_link();
    test_half();
    test_back_to_back();
    test_halt();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
